// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: control word, funct3 encodings,
// FSM states and the access-size helper.
package mem_stage_pkg;

  typedef struct packed {
    logic       reg_write;
    logic [4:0] rd;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
  } control_type;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } mem_size_e;

  // Unsigned variants only exist for loads; anything undefined is a word.
  function automatic mem_size_e size_of(
    input logic [2:0] f3,
    input logic       st
  );
    mem_size_e s;
    s = SZ_W;
    if (f3 == F3_B || (!st && f3 == F3_BU))
      s = SZ_B;
    else if (f3 == F3_H || (!st && f3 == F3_HU))
      s = SZ_H;
    return s;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: enables and replicated data for stores,
// lane extraction with sign/zero extension for loads.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic        store,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misaligned
);

  mem_size_e   size;
  logic        sx;
  logic [7:0]  byte_l;
  logic [15:0] half_l;

  assign size   = size_of(funct3, store);
  assign sx     = ~funct3[2];
  assign half_l = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    byte_l = rdata[7:0];
    unique case (off)
      2'd0: byte_l = rdata[7:0];
      2'd1: byte_l = rdata[15:8];
      2'd2: byte_l = rdata[23:16];
      2'd3: byte_l = rdata[31:24];
    endcase
  end

  always_comb begin
    be         = 4'b1111;
    wdata      = sdata;
    ldata      = rdata;
    misaligned = 1'b0;
    unique case (1'b1)
      size == SZ_B: begin
        be    = 4'b0001 << off;
        wdata = {4{sdata[7:0]}};
        ldata = {{24{sx & byte_l[7]}}, byte_l};
      end
      size == SZ_H: begin
        be         = off[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{sdata[15:0]}};
        ldata      = {{16{sx & half_l[15]}}, half_l};
        misaligned = off[0];
      end
      default: begin
        misaligned = |off;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: req/gnt/rvalid data access with alignment,
// flush draining and bounded wait.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] alu_data,
  input  logic [31:0] memory_data,
  input  control_type control_in,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output control_type control_out,
  output logic        misaligned,
  output logic        timeout_err
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT - 1);

  mem_state_e  state, state_d;
  control_type op_ctrl;
  logic [31:0] op_alu;
  logic [7:0]  cnt;
  logic        idle, is_mem, accept, expire, done, tmo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ldata;
  logic        al_mis, bad;

  assign idle      = state == IDLE;
  assign ex_ready  = idle;
  assign is_mem    = control_in.mem_read | control_in.mem_write;
  assign accept    = ex_valid & idle & ~flush;
  assign expire    = cnt >= LIMIT;
  assign bad       = is_mem & al_mis;
  assign dmem_addr = {op_alu[31:2], 2'b00};

  // In IDLE the aligner sees the incoming op, otherwise the held one.
  mem_lane_align u_align (
    .off        (idle ? alu_data[1:0] : op_alu[1:0]),
    .funct3     (idle ? control_in.funct3 : op_ctrl.funct3),
    .store      (idle ? control_in.mem_write : op_ctrl.mem_write),
    .sdata      (memory_data),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .ldata      (al_ldata),
    .misaligned (al_mis)
  );

  always_comb begin
    state_d = state;
    done    = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      IDLE: if (accept && is_mem && !al_mis) state_d = REQ;
      REQ: begin
        if (flush)
          state_d = (dmem_gnt && !dmem_we && !dmem_rvalid) ? DRAIN : IDLE;
        else if (dmem_gnt && (dmem_we || dmem_rvalid)) begin
          state_d = IDLE;
          done    = 1'b1;
        end else if (dmem_gnt)
          state_d = WAIT;
        else if (expire) begin
          state_d = IDLE;
          tmo     = 1'b1;
        end
      end
      WAIT: begin
        if (flush)
          state_d = dmem_rvalid ? IDLE : DRAIN;
        else if (dmem_rvalid) begin
          state_d = IDLE;
          done    = 1'b1;
        end else if (expire) begin
          state_d = IDLE;
          tmo     = 1'b1;
        end
      end
      DRAIN: begin
        if (dmem_rvalid)
          state_d = IDLE;
        else if (expire) begin
          state_d = IDLE;
          tmo     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || state_d == IDLE) cnt <= '0;
    else if (!idle)                cnt <= cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_ctrl     <= '0;
      op_alu      <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      control_out <= '0;
      misaligned  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      wb_valid    <= 1'b0;
      misaligned  <= 1'b0;
      timeout_err <= tmo;
      dmem_req    <= state_d == REQ;
      if (accept) begin
        op_ctrl    <= control_in;
        op_alu     <= alu_data;
        dmem_we    <= control_in.mem_write;
        dmem_be    <= al_be;
        dmem_wdata <= al_wdata;
        if (!is_mem || bad) begin
          wb_valid    <= 1'b1;
          wb_data     <= bad ? 32'h0 : alu_data;
          misaligned  <= bad;
          control_out <= control_in;
        end
      end
      if (done) begin
        wb_valid    <= 1'b1;
        wb_data     <= dmem_we ? op_alu : al_ldata;
        control_out <= op_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, stores, loads,
// misalignment, flush drain, reset and timeout.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, ex_valid, flush;
  logic [31:0] alu_data, memory_data, dmem_rdata;
  control_type control_in;
  logic        dmem_gnt, dmem_rvalid;

  logic        ex_ready, dmem_req, dmem_we, wb_valid, misaligned, timeout_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_be;
  control_type control_out;

  logic        t_ex_ready, t_req, t_we, t_wb_valid, t_mis, t_tmo;
  logic [31:0] t_addr, t_wdata, t_wb_data;
  logic [3:0]  t_be;
  control_type t_ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage u_dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_data(alu_data), .memory_data(memory_data),
    .control_in(control_in), .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .control_out(control_out),
    .misaligned(misaligned), .timeout_err(timeout_err)
  );

  mem_stage #(.MAX_WAIT(4)) u_tmo (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(t_ex_ready),
    .alu_data(alu_data), .memory_data(memory_data),
    .control_in(control_in), .flush(flush),
    .dmem_req(t_req), .dmem_we(t_we), .dmem_addr(t_addr),
    .dmem_be(t_be), .dmem_wdata(t_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(t_wb_valid), .wb_data(t_wb_data), .control_out(t_ctrl),
    .misaligned(t_mis), .timeout_err(t_tmo)
  );

  function automatic control_type mk(input logic rd_, input logic wr,
                                     input logic [2:0] f3);
    control_type c;
    c.reg_write = rd_;
    c.rd        = 5'd7;
    c.mem_read  = rd_;
    c.mem_write = wr;
    c.funct3    = f3;
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ex_valid = 1'b0; flush = 1'b0;
    alu_data = '0; memory_data = '0; control_in = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic issue(input control_type c, input logic [31:0] a,
                       input logic [31:0] d);
    ex_valid = 1'b1; control_in = c; alu_data = a; memory_data = d;
    step();
    ex_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ex_ready); end
    n_checks++; if ({dmem_req, wb_valid, timeout_err, misaligned} !== 4'b0) begin n_fail++; $display("FAIL reset_outs got %b want 0000", {dmem_req, wb_valid, timeout_err, misaligned}); end
    n_checks++; if (control_out !== control_type'('0)) begin n_fail++; $display("FAIL reset_ctrl got %h want 0", control_out); end
  endtask

  task automatic test_passthrough();
    issue(mk(1'b0, 1'b0, 3'b000), 32'h1234, 32'h0);
    n_checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h1234) begin n_fail++; $display("FAIL add_wb got %b/%h want 1/00001234", wb_valid, wb_data); end
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL add_noreq got %b want 0", dmem_req); end
    step();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL add_pulse got %b want 0", wb_valid); end
  endtask

  task automatic test_back_to_back();
    ex_valid = 1'b1; control_in = mk(1'b0, 1'b0, 3'b000);
    alu_data = 32'h11; step();
    alu_data = 32'h22; step();
    n_checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h22) begin n_fail++; $display("FAIL b2b_second got %b/%h want 1/00000022", wb_valid, wb_data); end
    ex_valid = 1'b0; step();
  endtask

  task automatic test_flush_idle();
    ex_valid = 1'b1; flush = 1'b1; control_in = mk(1'b0, 1'b0, 3'b000);
    alu_data = 32'h55; step();
    ex_valid = 1'b0; flush = 1'b0;
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle_block got %b want 0", wb_valid); end
  endtask

  task automatic test_store();
    issue(mk(1'b0, 1'b1, F3_B), 32'h1003, 32'hAB);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 1'b1, 32'h1000, 4'b1000, 32'hABABABAB}) begin
        n_fail++;
        $display("FAIL sb_req[%0d] got req=%b we=%b a=%h be=%b d=%h want 1 1 00001000 1000 abababab", i, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
      end
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL sb_early_wb[%0d] got %b want 0", i, wb_valid); end
      if (i == 2) dmem_gnt = 1'b1;
      step();
    end
    dmem_gnt = 1'b0;
    n_checks++; if (wb_valid !== 1'b1 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL sb_done got wb=%b req=%b want 1 0", wb_valid, dmem_req); end
    n_checks++; if (control_out !== mk(1'b0, 1'b1, F3_B)) begin n_fail++; $display("FAIL sb_ctrl got %h want %h", control_out, mk(1'b0, 1'b1, F3_B)); end
    step();
    issue(mk(1'b0, 1'b1, F3_H), 32'h1002, 32'h1234BEEF);
    n_checks++; if (dmem_be !== 4'b1100 || dmem_wdata !== 32'hBEEFBEEF) begin n_fail++; $display("FAIL sh_lane got be=%b d=%h want 1100 beefbeef", dmem_be, dmem_wdata); end
    dmem_gnt = 1'b1; step(); dmem_gnt = 1'b0; step();
  endtask

  task automatic do_load(input string nm, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] rd,
                         input logic [31:0] exp, input logic same);
    issue(mk(1'b1, 1'b0, f3), a, 32'h0);
    n_checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== {a[31:2], 2'b00}) begin n_fail++; $display("FAIL %s_req got req=%b we=%b a=%h want 1 0 %h", nm, dmem_req, dmem_we, dmem_addr, {a[31:2], 2'b00}); end
    dmem_gnt = 1'b1;
    if (same) begin dmem_rvalid = 1'b1; dmem_rdata = rd; end
    step();
    dmem_gnt = 1'b0;
    if (!same) begin dmem_rvalid = 1'b1; dmem_rdata = rd; step(); end
    dmem_rvalid = 1'b0;
    n_checks++; if (wb_valid !== 1'b1 || wb_data !== exp) begin n_fail++; $display("FAIL %s_data got %b/%h want 1/%h", nm, wb_valid, wb_data, exp); end
    step();
  endtask

  task automatic test_loads();
    do_load("lb",  F3_B,  32'h2001, 32'h00008000, 32'hFFFFFF80, 1'b0);
    do_load("lbu", F3_BU, 32'h2001, 32'h00008000, 32'h00000080, 1'b0);
    do_load("lh",  F3_H,  32'h2002, 32'h80010000, 32'hFFFF8001, 1'b0);
    do_load("lhu", F3_HU, 32'h2002, 32'h80010000, 32'h00008001, 1'b0);
    do_load("lw_same", F3_W, 32'h2004, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1);
  endtask

  task automatic test_misaligned();
    issue(mk(1'b1, 1'b0, F3_W), 32'h2002, 32'h0);
    n_checks++; if ({wb_valid, misaligned, dmem_req} !== 3'b110 || wb_data !== 32'h0) begin n_fail++; $display("FAIL lw_mis got v=%b m=%b req=%b d=%h want 1 1 0 0", wb_valid, misaligned, dmem_req, wb_data); end
    step();
    issue(mk(1'b0, 1'b1, F3_H), 32'h1001, 32'h0);
    n_checks++; if ({wb_valid, misaligned, dmem_req} !== 3'b110) begin n_fail++; $display("FAIL sh_mis got v=%b m=%b req=%b want 1 1 0", wb_valid, misaligned, dmem_req); end
    step();
  endtask

  task automatic test_flush_wait();
    int seen;
    seen = 0;
    issue(mk(1'b1, 1'b0, F3_W), 32'h3000, 32'h0);
    dmem_gnt = 1'b1; step(); dmem_gnt = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    seen += int'(wb_valid);
    step(); seen += int'(wb_valid);
    n_checks++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL drain_busy got %b want 0", ex_ready); end
    step(); seen += int'(wb_valid);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1; step(); dmem_rvalid = 1'b0;
    seen += int'(wb_valid);
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL drain_wb got %0d pulses want 0", seen); end
    n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready got %b want 1", ex_ready); end
  endtask

  task automatic test_reset_mid();
    issue(mk(1'b1, 1'b0, F3_W), 32'h3100, 32'h0);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    n_checks++; if (dmem_req !== 1'b0 || ex_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid got req=%b rdy=%b want 0 1", dmem_req, ex_ready); end
    dmem_rvalid = 1'b1; step(); dmem_rvalid = 1'b0;
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_late_rvalid got %b want 0", wb_valid); end
  endtask

  task automatic test_timeout();
    do_reset();
    issue(mk(1'b1, 1'b0, F3_W), 32'h4000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (t_req !== 1'b1 || t_tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_hold[%0d] got req=%b err=%b want 1 0", i, t_req, t_tmo); end
      step();
    end
    n_checks++; if ({t_req, t_tmo, t_ex_ready, t_wb_valid} !== 4'b0110) begin n_fail++; $display("FAIL tmo_abort got req/err/rdy/wb=%b want 0110", {t_req, t_tmo, t_ex_ready, t_wb_valid}); end
    step();
    n_checks++; if (t_tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse got %b want 0", t_tmo); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_flush_idle();
    test_store();
    test_loads();
    test_misaligned();
    test_flush_wait();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
